// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard scoreboard: FSM state encoding,
// scoreboard counter width and the operand dependency check.
package hazard_pkg;

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } redirect_state_e;

    // An operand depends on an older result when it is read and either a
    // load counter is still running or the outstanding MDU op targets it.
    // late_ok drops the hazard on the final counter cycle (WB->MEM forward).
    function automatic logic check_dependency(
        input logic used,
        input logic sb_pend,
        input logic sb_last,
        input logic mdu_hit,
        input logic late_ok
    );
        return used & ((sb_pend & ~(late_ok & sb_last)) | mdu_hit);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bus: instruction info into the hazard unit, pipeline
// control back out. master = pipeline side, slave = hazard_scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] rs1_ID;
    logic [REG_ADDR_W-1:0] rs2_ID;
    logic [REG_ADDR_W-1:0] rd_ID;
    logic rs1_used_ID;
    logic rs2_used_ID;
    logic RegWrite_ID;
    logic MemRead_ID;
    logic MemWrite_ID;
    logic IsMDU_ID;
    logic IsBranch_ID;
    logic IsJAL_ID;
    logic IsJALR_ID;
    logic branch_result;
    logic id_valid;
    logic mdu_done;
    logic trap_taken;
    logic mret_taken;
    logic stall;
    logic flush_IFID;
    logic flush_IDEX;
    logic flush_EXMEM;
    logic flush_MEMWB;
    logic branch_taken;
    logic mdu_kill;
    logic redirect_busy;

    modport master (
        output rs1_ID, rs2_ID, rd_ID, rs1_used_ID, rs2_used_ID, RegWrite_ID,
               MemRead_ID, MemWrite_ID, IsMDU_ID, IsBranch_ID, IsJAL_ID,
               IsJALR_ID, branch_result, id_valid, mdu_done, trap_taken,
               mret_taken,
        input  stall, flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB,
               branch_taken, mdu_kill, redirect_busy
    );

    modport slave (
        input  rs1_ID, rs2_ID, rd_ID, rs1_used_ID, rs2_used_ID, RegWrite_ID,
               MemRead_ID, MemWrite_ID, IsMDU_ID, IsBranch_ID, IsJAL_ID,
               IsJALR_ID, branch_result, id_valid, mdu_done, trap_taken,
               mret_taken,
        output stall, flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB,
               branch_taken, mdu_kill, redirect_busy
    );
endinterface

// File: rtl/hazard_scoreboard_sb.sv
// Per-register load countdown array. One set port, a global clear and two
// read ports reporting "still pending" and "on its final cycle".
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned SET_VAL = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear_all,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              pend_a,
    output logic              last_a,
    output logic              pend_b,
    output logic              last_b
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [CNT_W-1:0] cnt [DEPTH];

    // Counter update: clear beats set, set beats the free-running decrement; x0 never marked.
    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < DEPTH; r++) begin
            if (!rstn || clear_all) begin
                cnt[r] <= '0;
            end else if (set_en && (set_addr == ADDR_W'(r)) && (r != 0)) begin
                cnt[r] <= CNT_W'(SET_VAL);
            end else if (cnt[r] != '0) begin
                cnt[r] <= cnt[r] - CNT_W'(1);
            end
        end
    end

    // Read ports.
    always_comb begin
        pend_a = (cnt[rd_addr_a] != '0);
        last_a = (cnt[rd_addr_a] == CNT_W'(1));
        pend_b = (cnt[rd_addr_b] != '0);
        last_b = (cnt[rd_addr_b] == CNT_W'(1));
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit with per-register load scoreboard, one outstanding
// MDU op and a trap/mret redirect FSM. Optional HAZARD_PERF_EN adds
// saturating stall/flush event counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W      = 5,
    parameter int unsigned MEM_LAT         = 1,
    parameter int unsigned REDIRECT_CYCLES = 1
) (
    input  logic clk,
    input  logic rstn,
    hazard_scoreboard_if.slave bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);
    redirect_state_e        state, state_d;
    logic                   trap_q, trap_d;
    logic [3:0]             rcnt, rcnt_d;
    logic                   mdu_pend;
    logic [REG_ADDR_W-1:0]  mdu_rd;
    logic                   pend_1, last_1, pend_2, last_2;
    logic                   rs1_haz, rs2_haz, struct_haz, haz, bt_raw;
    logic                   issue, sb_clear;
    logic                   stall, flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB;
    logic                   branch_taken, mdu_kill;

    hazard_sb #(
        .ADDR_W  (REG_ADDR_W),
        .SET_VAL (MEM_LAT + 1)
    ) u_sb (
        .clk       (clk),
        .rstn      (rstn),
        .clear_all (sb_clear),
        .set_en    (issue && bus.MemRead_ID && bus.RegWrite_ID),
        .set_addr  (bus.rd_ID),
        .rd_addr_a (bus.rs1_ID),
        .rd_addr_b (bus.rs2_ID),
        .pend_a    (pend_1),
        .last_a    (last_1),
        .pend_b    (pend_2),
        .last_b    (last_2)
    );

    // Operand, structural and control-flow hazards from registered state.
    always_comb begin
        rs1_haz = bus.id_valid & check_dependency(bus.rs1_used_ID, pend_1, last_1,
                      mdu_pend && (mdu_rd == bus.rs1_ID), 1'b0);
        rs2_haz = bus.id_valid & check_dependency(bus.rs2_used_ID, pend_2, last_2,
                      mdu_pend && (mdu_rd == bus.rs2_ID),
                      bus.MemWrite_ID & ~bus.IsBranch_ID & ~bus.IsJALR_ID);
        struct_haz = bus.id_valid & bus.IsMDU_ID & mdu_pend;
        haz = rs1_haz | rs2_haz | struct_haz;
        bt_raw = bus.id_valid & ((bus.IsBranch_ID & bus.branch_result & ~rs1_haz & ~rs2_haz)
                 | bus.IsJAL_ID | (bus.IsJALR_ID & ~rs1_haz));
        issue = (state == IDLE) & bus.id_valid & ~haz;
    end

    // Redirect FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            trap_q <= 1'b0;
            rcnt   <= '0;
        end else begin
            state  <= state_d;
            trap_q <= trap_d;
            rcnt   <= rcnt_d;
        end
    end

    // Redirect FSM next state and pipeline control outputs.
    always_comb begin
        state_d      = state;
        trap_d       = trap_q;
        rcnt_d       = rcnt;
        stall        = 1'b0;
        flush_IFID   = 1'b0;
        flush_IDEX   = 1'b0;
        flush_EXMEM  = 1'b0;
        flush_MEMWB  = 1'b0;
        branch_taken = 1'b0;
        mdu_kill     = 1'b0;
        sb_clear     = 1'b0;
        case (state)
            IDLE: begin
                stall        = haz;
                flush_IDEX   = haz;
                branch_taken = bt_raw;
                flush_IFID   = bt_raw;
                if (bus.trap_taken || bus.mret_taken) begin
                    state_d = FLUSH;
                    trap_d  = bus.trap_taken;
                end
            end
            FLUSH: begin
                flush_IFID  = 1'b1;
                flush_IDEX  = 1'b1;
                flush_EXMEM = 1'b1;
                flush_MEMWB = trap_q;
                mdu_kill    = mdu_pend;
                sb_clear    = 1'b1;
                if (bus.trap_taken) begin
                    trap_d = 1'b1;
                end else begin
                    state_d = REDIRECT;
                    rcnt_d  = 4'(REDIRECT_CYCLES);
                end
            end
            REDIRECT: begin
                flush_IFID = 1'b1;
                flush_IDEX = 1'b1;
                if (bus.trap_taken) begin
                    state_d = FLUSH;
                    trap_d  = 1'b1;
                end else if (rcnt <= 4'd1) begin
                    state_d = IDLE;
                end else begin
                    rcnt_d = rcnt - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outstanding MDU op: issue sets, completion or FLUSH clears.
    always_ff @(posedge clk) begin
        if (!rstn || sb_clear) begin
            mdu_pend <= 1'b0;
            mdu_rd   <= '0;
        end else if (issue && bus.IsMDU_ID && (bus.rd_ID != '0)) begin
            mdu_pend <= 1'b1;
            mdu_rd   <= bus.rd_ID;
        end else if (bus.mdu_done) begin
            mdu_pend <= 1'b0;
        end
    end

    assign bus.stall         = stall;
    assign bus.flush_IFID    = flush_IFID;
    assign bus.flush_IDEX    = flush_IDEX;
    assign bus.flush_EXMEM   = flush_EXMEM;
    assign bus.flush_MEMWB   = flush_MEMWB;
    assign bus.branch_taken  = branch_taken;
    assign bus.mdu_kill      = mdu_kill;
    assign bus.redirect_busy = (state != IDLE);

`ifdef HAZARD_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if ((branch_taken || (state_d == FLUSH)) && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
